pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller. Generates the per-stage `stall_valid` and `flush_valid` vectors consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also produces the PC redirect for branch, trap and mret events. When a redirect arrives while an instruction fetch is outstanding, it holds the redirect pending and sequences it once the fetch retires.

Parameters:
XLEN, 64, PC/target width
PERF_W, 32, width of saturating stall-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
if_busy_i  in  1  IF fetch outstanding, instruction not yet returned
load_use_i  in  1  ID detects load-use hazard on EX-stage load
mem_busy_i  in  1  LSU access in MEM not complete
branch_valid_i  in  1  EX resolved taken branch/jump mispredict
branch_target_i  in  XLEN  branch target
trap_valid_i  in  1  MEM-stage exception/interrupt taken
trap_target_i  in  XLEN  mtvec-derived handler address
mret_valid_i  in  1  MEM-stage mret
mret_target_i  in  XLEN  mepc
stall_valid_o  out  6  per-stage hold, bit index per CTRLBUS_*
flush_valid_o  out  6  per-stage bubble insert, bit index per CTRLBUS_*
redirect_valid_o  out  1  PC loads redirect_pc_o this cycle
redirect_pc_o  out  XLEN  redirect address
stall_cycles_o  out  PERF_W  cycles with PC stalled, saturating

Behaviour:
- Clock `clk`, reset `rst`. One clock domain. Reset is synchronous and active-high.
- Bit map: PC=0, IF_ID=1, ID_EX=2, EX_MEM=3, MEM_WB=4, WB=5 (reserved, always 0).
- Invariant: `(stall_valid_o & flush_valid_o) == 0` every cycle. A pipeline register with both bits set holds, so the flush would be lost.
- `stall_valid_o`, `flush_valid_o` and `redirect_*` are combinational from the inputs and the registered state (zero-latency).
- While `rst`=1, all outputs are 0. After reset: state=RUN, pending target=0, `stall_cycles_o`=0.
- FSM states:
  - RUN
  - WAIT_FETCH: a redirect is pending behind an outstanding fetch.
- Event priority: trap > mret > branch. Trap and mret are sampled only when `mem_busy_i`=0; the LSU raises them only after completion.
- RUN rules, with OR-composition and higher rows winning on conflict:
  - Redirect event with `if_busy_i`=0:
    - `redirect_valid_o`=1 with the selected target.
    - Trap/mret flushes IF_ID, ID_EX, EX_MEM. Branch flushes IF_ID, ID_EX.
    - No stalls on flushed stages. PC not stalled.
  - Redirect event with `if_busy_i`=1:
    - Latch the target and go to WAIT_FETCH.
    - Same flush set as above. Stall PC. `redirect_valid_o`=0.
  - `mem_busy_i`=1: stall PC, IF_ID, ID_EX, EX_MEM; flush MEM_WB.
  - `load_use_i`=1 and no redirect: stall PC, IF_ID; flush ID_EX.
  - `if_busy_i`=1: stall PC; flush IF_ID, unless IF_ID is stalled by a row above.
- WAIT_FETCH rules:
  - Each cycle: stall PC, flush IF_ID. The returning stale instruction is dropped.
  - If `if_busy_i`=0: `redirect_valid_o`=1, `redirect_pc_o`=latched target, return to RUN.
  - A trap or mret arriving in WAIT_FETCH overwrites the latched target and flushes IF_ID, ID_EX, EX_MEM. This applies even in the exit cycle: the new target is the one issued.
  - `branch_valid_i` in WAIT_FETCH is ignored (ID_EX is empty).
  - `mem_busy_i` stalls apply as in RUN.
- `stall_cycles_o` increments on every cycle where `stall_valid_o[0]`=1 and saturates at all-ones.
- If reset is asserted in WAIT_FETCH, the pending redirect is discarded.

Decomposition:
- sysconfig gains CTRLBUS_PC, CTRLBUS_IF_ID, CTRLBUS_ID_EX, CTRLBUS_EX_MEM, CTRLBUS_MEM_WB, CTRLBUS_WB.
- sysconfig also gains the state encodings PIPE_RUN=1'b0 and PIPE_WAIT_FETCH=1'b1.
- State, pending target and counter use regTemplate instances. No other sub-module.

Test Plan:
- `load_use_i`=1 for one cycle, nothing else active -> stall=6'b000011, flush=6'b000100, no redirect.
- `mem_busy_i`=1 for 3 cycles with `load_use_i`=1 -> stall=6'b001111 and flush=6'b010000 for all 3 cycles; `stall_cycles_o` advances by 3.
- `branch_valid_i`=1, target 0x8000_0040, `if_busy_i`=0 -> same-cycle redirect to 0x8000_0040, flush=6'b000110, stall=0.
- `branch_valid_i`=1 (target 0x100) with `if_busy_i`=1 for 4 cycles -> WAIT_FETCH; stall[0]=1 and flush[1]=1 for 4 cycles; redirect to 0x100 in the cycle `if_busy_i` falls.
- In WAIT_FETCH (pending 0x100), `trap_valid_i`=1 with target 0x8000_0000 -> flush=6'b001110; later redirect issues 0x8000_0000, not 0x100.
- `trap_valid_i`=1 together with `branch_valid_i`=1 -> trap target wins, flush=6'b001110. Assert `rst` in WAIT_FETCH -> all outputs 0 next cycle, no redirect.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: control-bus bit map, FSM encoding
// and the stage masks used when composing stall/flush vectors.
package pipe_ctrl_pkg;

    localparam int unsigned CTRLBUS_W      = 6;
    localparam int unsigned CTRLBUS_PC     = 0;
    localparam int unsigned CTRLBUS_IF_ID  = 1;
    localparam int unsigned CTRLBUS_ID_EX  = 2;
    localparam int unsigned CTRLBUS_EX_MEM = 3;
    localparam int unsigned CTRLBUS_MEM_WB = 4;
    localparam int unsigned CTRLBUS_WB     = 5;

    typedef enum logic {
        PIPE_RUN        = 1'b0,
        PIPE_WAIT_FETCH = 1'b1
    } pipe_state_e;

    function automatic logic [CTRLBUS_W-1:0] ctrl_bit(input int unsigned idx);
        return CTRLBUS_W'(1) << idx;
    endfunction

    localparam logic [CTRLBUS_W-1:0] FLUSH_BRANCH =
        ctrl_bit(CTRLBUS_IF_ID) | ctrl_bit(CTRLBUS_ID_EX);
    localparam logic [CTRLBUS_W-1:0] FLUSH_SYS =
        FLUSH_BRANCH | ctrl_bit(CTRLBUS_EX_MEM);
    localparam logic [CTRLBUS_W-1:0] STALL_MEM =
        ctrl_bit(CTRLBUS_PC) | ctrl_bit(CTRLBUS_IF_ID) |
        ctrl_bit(CTRLBUS_ID_EX) | ctrl_bit(CTRLBUS_EX_MEM);

endpackage

// File: rtl/pipe_ctrl_reg.sv
// Generic register with synchronous active-high reset and load enable.
module pipe_ctrl_reg #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall/flush vectors, PC redirect sequencing behind
// outstanding fetches, and a saturating PC-stall cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_busy_i,
    input  logic                 load_use_i,
    input  logic                 mem_busy_i,
    input  logic                 branch_valid_i,
    input  logic [XLEN-1:0]      branch_target_i,
    input  logic                 trap_valid_i,
    input  logic [XLEN-1:0]      trap_target_i,
    input  logic                 mret_valid_i,
    input  logic [XLEN-1:0]      mret_target_i,
    output logic [CTRLBUS_W-1:0] stall_valid_o,
    output logic [CTRLBUS_W-1:0] flush_valid_o,
    output logic                 redirect_valid_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic [PERF_W-1:0]    stall_cycles_o
);

    pipe_state_e           state_q;
    pipe_state_e           state_d;
    logic                  state_raw;
    logic [XLEN-1:0]       pend_q;
    logic [XLEN-1:0]       pend_d;
    logic                  pend_en;
    logic [PERF_W-1:0]     cnt_q;
    logic                  cnt_en;

    logic [CTRLBUS_W-1:0]  stall_c;
    logic [CTRLBUS_W-1:0]  flush_c;
    logic                  redir_c;
    logic [XLEN-1:0]       redir_pc_c;

    logic                  trap_evt;
    logic                  mret_evt;
    logic                  sys_evt;
    logic                  any_evt;
    logic [XLEN-1:0]       sys_tgt;
    logic [XLEN-1:0]       evt_tgt;
    logic [CTRLBUS_W-1:0]  evt_mask;

    // Trap/mret only count once the LSU has finished; trap outranks mret outranks branch.
    assign trap_evt = trap_valid_i & ~mem_busy_i;
    assign mret_evt = mret_valid_i & ~mem_busy_i;
    assign sys_evt  = trap_evt | mret_evt;
    assign any_evt  = sys_evt | branch_valid_i;
    assign sys_tgt  = trap_evt ? trap_target_i : mret_target_i;
    assign evt_tgt  = sys_evt ? sys_tgt : branch_target_i;
    assign evt_mask = sys_evt ? FLUSH_SYS : FLUSH_BRANCH;

    assign state_q = pipe_state_e'(state_raw);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_en    = 1'b0;
        stall_c    = '0;
        flush_c    = '0;
        redir_c    = 1'b0;
        redir_pc_c = '0;

        case (state_q)
            PIPE_RUN: begin
                // Lowest-priority rows first; later rows override on conflict.
                if (if_busy_i) begin
                    stall_c[CTRLBUS_PC]    = 1'b1;
                    flush_c[CTRLBUS_IF_ID] = 1'b1;
                end
                if (load_use_i && !any_evt) begin
                    stall_c[CTRLBUS_PC]    = 1'b1;
                    stall_c[CTRLBUS_IF_ID] = 1'b1;
                    flush_c[CTRLBUS_ID_EX] = 1'b1;
                end
                if (mem_busy_i) begin
                    stall_c                 = stall_c | STALL_MEM;
                    flush_c[CTRLBUS_MEM_WB] = 1'b1;
                end
                flush_c = flush_c & ~stall_c;
                if (any_evt) begin
                    flush_c             = flush_c | evt_mask;
                    stall_c             = stall_c & ~evt_mask;
                    stall_c[CTRLBUS_PC] = if_busy_i;
                    if (if_busy_i) begin
                        pend_d  = evt_tgt;
                        pend_en = 1'b1;
                        state_d = PIPE_WAIT_FETCH;
                    end else begin
                        redir_c    = 1'b1;
                        redir_pc_c = evt_tgt;
                    end
                end
            end
            PIPE_WAIT_FETCH: begin
                if (mem_busy_i) begin
                    stall_c                 = STALL_MEM;
                    flush_c[CTRLBUS_MEM_WB] = 1'b1;
                end
                // IF_ID only ever holds the stale fetch here, so dropping it wins.
                stall_c[CTRLBUS_PC]    = 1'b1;
                stall_c[CTRLBUS_IF_ID] = 1'b0;
                flush_c[CTRLBUS_IF_ID] = 1'b1;
                if (sys_evt) begin
                    flush_c = flush_c | FLUSH_SYS;
                    stall_c = stall_c & ~FLUSH_SYS;
                    pend_d  = sys_tgt;
                    pend_en = 1'b1;
                end
                if (!if_busy_i) begin
                    stall_c[CTRLBUS_PC] = 1'b0;
                    redir_c             = 1'b1;
                    redir_pc_c          = sys_evt ? sys_tgt : pend_q;
                    state_d             = PIPE_RUN;
                end
            end
            default: begin
                state_d = PIPE_RUN;
            end
        endcase
    end

    assign stall_valid_o    = rst ? '0 : stall_c;
    assign flush_valid_o    = rst ? '0 : flush_c;
    assign redirect_valid_o = rst ? 1'b0 : redir_c;
    assign redirect_pc_o    = rst ? '0 : redir_pc_c;
    assign stall_cycles_o   = rst ? '0 : cnt_q;

    assign cnt_en = stall_valid_o[CTRLBUS_PC] & ~(&cnt_q);

    pipe_ctrl_reg #(.W(1), .RST_VAL(1'b0)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (1'(state_d)),
        .q   (state_raw)
    );

    pipe_ctrl_reg #(.W(XLEN), .RST_VAL('0)) u_pend_reg (
        .clk (clk),
        .rst (rst),
        .en  (pend_en),
        .d   (pend_d),
        .q   (pend_q)
    );

    pipe_ctrl_reg #(.W(PERF_W), .RST_VAL('0)) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .d   (cnt_q + PERF_W'(1)),
        .q   (cnt_q)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-stage action model checked every cycle plus directed
// vectors with hand-computed stall/flush/redirect values.
module tb_pipe_ctrl;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PERF_W = 4;
    localparam int unsigned CNT_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_busy_i = 1'b0;
    logic              load_use_i = 1'b0;
    logic              mem_busy_i = 1'b0;
    logic              branch_valid_i = 1'b0;
    logic [XLEN-1:0]   branch_target_i = '0;
    logic              trap_valid_i = 1'b0;
    logic [XLEN-1:0]   trap_target_i = '0;
    logic              mret_valid_i = 1'b0;
    logic [XLEN-1:0]   mret_target_i = '0;
    logic [5:0]        stall_valid_o;
    logic [5:0]        flush_valid_o;
    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic [PERF_W-1:0] stall_cycles_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_busy_i        (if_busy_i),
        .load_use_i       (load_use_i),
        .mem_busy_i       (mem_busy_i),
        .branch_valid_i   (branch_valid_i),
        .branch_target_i  (branch_target_i),
        .trap_valid_i     (trap_valid_i),
        .trap_target_i    (trap_target_i),
        .mret_valid_i     (mret_valid_i),
        .mret_target_i    (mret_target_i),
        .stall_valid_o    (stall_valid_o),
        .flush_valid_o    (flush_valid_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each stage gets an action; rules are applied lowest priority first.
    typedef enum int {A_NONE, A_HOLD, A_BUB} act_t;

    logic              m_wait = 1'b0;
    logic [XLEN-1:0]   m_pend = '0;
    int unsigned       m_cnt = 0;
    logic              m_wait_nx = 1'b0;
    logic [XLEN-1:0]   m_pend_nx = '0;
    int unsigned       m_cnt_nx = 0;

    always @(negedge clk) begin
        act_t            act [6];
        logic [5:0]      es;
        logic [5:0]      ef;
        logic            er;
        logic [XLEN-1:0] epc;
        logic            sys_hit;
        logic [XLEN-1:0] sys_t;
        int unsigned     ecnt;

        es = '0; ef = '0; er = 1'b0; epc = '0;
        for (int i = 0; i < 6; i++) act[i] = A_NONE;
        m_wait_nx = m_wait;
        m_pend_nx = m_pend;
        sys_hit = (trap_valid_i || mret_valid_i) && !mem_busy_i;
        sys_t   = (trap_valid_i && !mem_busy_i) ? trap_target_i : mret_target_i;

        if (rst) begin
            m_wait_nx = 1'b0;
            m_pend_nx = '0;
            ecnt = 0;
            m_cnt_nx = 0;
        end else begin
            if (!m_wait) begin
                logic any;
                logic [XLEN-1:0] tgt;
                any = sys_hit || branch_valid_i;
                tgt = sys_hit ? sys_t : branch_target_i;
                if (if_busy_i) begin act[0] = A_HOLD; act[1] = A_BUB; end
                if (load_use_i && !any) begin
                    act[0] = A_HOLD; act[1] = A_HOLD; act[2] = A_BUB;
                end
                if (mem_busy_i) begin
                    for (int i = 0; i < 4; i++) act[i] = A_HOLD;
                    act[4] = A_BUB;
                end
                if (any) begin
                    act[1] = A_BUB; act[2] = A_BUB;
                    if (sys_hit) act[3] = A_BUB;
                    act[0] = if_busy_i ? A_HOLD : A_NONE;
                    if (if_busy_i) begin
                        m_wait_nx = 1'b1;
                        m_pend_nx = tgt;
                    end else begin
                        er = 1'b1;
                        epc = tgt;
                    end
                end
            end else begin
                if (mem_busy_i) begin
                    for (int i = 0; i < 4; i++) act[i] = A_HOLD;
                    act[4] = A_BUB;
                end
                act[0] = A_HOLD; act[1] = A_BUB;
                if (sys_hit) begin
                    act[1] = A_BUB; act[2] = A_BUB; act[3] = A_BUB;
                    m_pend_nx = sys_t;
                end
                if (!if_busy_i) begin
                    act[0] = A_NONE;
                    er = 1'b1;
                    epc = sys_hit ? sys_t : m_pend;
                    m_wait_nx = 1'b0;
                end
            end
            for (int i = 0; i < 6; i++) begin
                es[i] = (act[i] == A_HOLD);
                ef[i] = (act[i] == A_BUB);
            end
            ecnt = m_cnt;
            m_cnt_nx = es[0] ? ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1) : m_cnt;
        end

        chk("model_stall", 64'(stall_valid_o), 64'(es));
        chk("model_flush", 64'(flush_valid_o), 64'(ef));
        chk("model_redir", 64'(redirect_valid_o), 64'(er));
        if (er) chk("model_redir_pc", redirect_pc_o, epc);
        chk("model_stall_cycles", 64'(stall_cycles_o), 64'(ecnt));
        chk("model_no_overlap", 64'(stall_valid_o & flush_valid_o), 64'(0));
    end

    always @(posedge clk) begin
        m_wait <= m_wait_nx;
        m_pend <= m_pend_nx;
        m_cnt  <= m_cnt_nx;
    end

    task automatic clr_in();
        if_busy_i = 1'b0; load_use_i = 1'b0; mem_busy_i = 1'b0;
        branch_valid_i = 1'b0; trap_valid_i = 1'b0; mret_valid_i = 1'b0;
        branch_target_i = '0; trap_target_i = '0; mret_target_i = '0;
    endtask

    // Check the current cycle against literals, then advance to just after the next edge.
    task automatic step(input string nm, input logic [5:0] s, input logic [5:0] f,
                        input logic r, input logic [XLEN-1:0] pc);
        @(negedge clk); #1;
        chk({nm, "_stall"}, 64'(stall_valid_o), 64'(s));
        chk({nm, "_flush"}, 64'(flush_valid_o), 64'(f));
        chk({nm, "_redir"}, 64'(redirect_valid_o), 64'(r));
        if (r) chk({nm, "_pc"}, redirect_pc_o, pc);
        @(posedge clk); #1;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        load_use_i = 1'b1;
        step("reset0", 6'b000000, 6'b000000, 1'b0, '0);
        step("reset1", 6'b000000, 6'b000000, 1'b0, '0);
        chk("reset_cnt", 64'(stall_cycles_o), 64'(0));
        rst = 1'b0; clr_in();
        step("idle", 6'b000000, 6'b000000, 1'b0, '0);

        load_use_i = 1'b1;
        step("load_use", 6'b000011, 6'b000100, 1'b0, '0);

        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_busy_lu", 6'b001111, 6'b010000, 1'b0, '0);
        clr_in();

        branch_valid_i = 1'b1; branch_target_i = 64'h8000_0040;
        step("branch_now", 6'b000000, 6'b000110, 1'b1, 64'h8000_0040);
        chk("cnt_after_mem", 64'(stall_cycles_o), 64'(4));

        branch_valid_i = 1'b1; branch_target_i = 64'h100; if_busy_i = 1'b1;
        step("branch_busy", 6'b000001, 6'b000110, 1'b0, '0);
        clr_in(); if_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) step("wait_fetch", 6'b000001, 6'b000010, 1'b0, '0);
        if_busy_i = 1'b0;
        step("wait_exit", 6'b000000, 6'b000010, 1'b1, 64'h100);

        branch_valid_i = 1'b1; branch_target_i = 64'h100; if_busy_i = 1'b1;
        step("branch_busy2", 6'b000001, 6'b000110, 1'b0, '0);
        clr_in(); if_busy_i = 1'b1;
        trap_valid_i = 1'b1; trap_target_i = 64'h8000_0000;
        step("wait_trap", 6'b000001, 6'b001110, 1'b0, '0);
        clr_in(); if_busy_i = 1'b1;
        step("wait_after_trap", 6'b000001, 6'b000010, 1'b0, '0);
        if_busy_i = 1'b0;
        step("wait_exit_trap", 6'b000000, 6'b000010, 1'b1, 64'h8000_0000);

        trap_valid_i = 1'b1; trap_target_i = 64'h8000_0000;
        branch_valid_i = 1'b1; branch_target_i = 64'h200;
        step("trap_vs_branch", 6'b000000, 6'b001110, 1'b1, 64'h8000_0000);
        clr_in();

        trap_valid_i = 1'b1; trap_target_i = 64'h8000_0000; mem_busy_i = 1'b1;
        step("trap_mem_busy", 6'b001111, 6'b010000, 1'b0, '0);
        clr_in();

        mret_valid_i = 1'b1; mret_target_i = 64'h1234;
        branch_valid_i = 1'b1; branch_target_i = 64'h200;
        step("mret_vs_branch", 6'b000000, 6'b001110, 1'b1, 64'h1234);
        clr_in();

        branch_valid_i = 1'b1; branch_target_i = 64'h240; load_use_i = 1'b1;
        step("branch_lu", 6'b000000, 6'b000110, 1'b1, 64'h240);
        clr_in();

        branch_valid_i = 1'b1; branch_target_i = 64'h200; if_busy_i = 1'b1;
        step("enter_wait_rst", 6'b000001, 6'b000110, 1'b0, '0);
        clr_in(); if_busy_i = 1'b1; rst = 1'b1;
        step("rst_in_wait", 6'b000000, 6'b000000, 1'b0, '0);
        chk("rst_in_wait_cnt", 64'(stall_cycles_o), 64'(0));
        rst = 1'b0; if_busy_i = 1'b0;
        step("after_rst", 6'b000000, 6'b000000, 1'b0, '0);

        branch_valid_i = 1'b1; branch_target_i = 64'h300; if_busy_i = 1'b1;
        step("enter_wait3", 6'b000001, 6'b000110, 1'b0, '0);
        clr_in(); trap_valid_i = 1'b1; trap_target_i = 64'h400;
        step("exit_with_trap", 6'b000000, 6'b001110, 1'b1, 64'h400);
        clr_in();

        if_busy_i = 1'b1;
        step("if_busy_only", 6'b000001, 6'b000010, 1'b0, '0);
        load_use_i = 1'b1;
        step("if_busy_lu", 6'b000011, 6'b000100, 1'b0, '0);
        clr_in();

        branch_valid_i = 1'b1; branch_target_i = 64'h500; if_busy_i = 1'b1;
        step("enter_wait4", 6'b000001, 6'b000110, 1'b0, '0);
        clr_in(); if_busy_i = 1'b1; mem_busy_i = 1'b1;
        branch_valid_i = 1'b1; branch_target_i = 64'h600;
        step("wait_mem_branch", 6'b001101, 6'b010010, 1'b0, '0);
        clr_in();
        step("exit_wait4", 6'b000000, 6'b000010, 1'b1, 64'h500);

        mem_busy_i = 1'b1;
        for (int i = 0; i < 20; i++) step("sat_mem", 6'b001111, 6'b010000, 1'b0, '0);
        clr_in();
        step("sat_idle", 6'b000000, 6'b000000, 1'b0, '0);
        chk("cnt_saturated", 64'(stall_cycles_o), 64'(CNT_MAX));

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
